// File: rtl/be_cmd_writer_pkg.sv
// rtl/be_cmd_writer_pkg.sv - shared opcodes, request kinds and writer FSM states (package be_cmd_pkg)
package be_cmd_pkg;

    localparam int CMD_WIDTH = 40;

    localparam logic [7:0] OP_PARAM_HI_BASE = 8'h88;
    localparam logic [7:0] OP_PARAM_LO      = 8'h87;
    localparam logic [7:0] OP_NOP           = 8'h80;
    localparam logic [7:0] OP_END           = 8'hBF;
    localparam logic [7:0] OP_WAIT_INTS     = 8'h40;

    typedef enum logic [1:0] {
        KIND_RAW     = 2'd0,
        KIND_PARAM64 = 2'd1,
        KIND_END     = 2'd2,
        KIND_RSVD    = 2'd3
    } req_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EMIT1 = 2'd2,
        ST_EMIT2 = 2'd3
    } wr_state_t;

    // A parameter write occupies two FIFO words; everything else one.
    function automatic logic [1:0] words_needed(input logic [1:0] kind);
        return (kind == KIND_PARAM64) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/be_cmd_writer_if.sv
// rtl/be_cmd_writer_if.sv - request handshake and command FIFO write bundle
interface be_cmd_writer_if #(
    parameter int ADDRESS_WIDTH = 4
);
    logic                             req_valid;
    logic                             req_ready;
    logic [1:0]                       req_kind;
    logic [2:0]                       req_slot;
    logic [63:0]                      req_data;
    logic                             fifo_write;
    logic [be_cmd_pkg::CMD_WIDTH-1:0] fifo_write_data;
    logic [ADDRESS_WIDTH:0]           fifo_data_count;

    // Host and FIFO side: issues requests, reports occupancy, receives words.
    modport master (
        output req_valid, req_kind, req_slot, req_data, fifo_data_count,
        input  req_ready, fifo_write, fifo_write_data
    );

    // Writer side.
    modport slave (
        input  req_valid, req_kind, req_slot, req_data, fifo_data_count,
        output req_ready, fifo_write, fifo_write_data
    );
endinterface

// File: rtl/be_cmd_writer_encode.sv
// rtl/be_cmd_writer_encode.sv - be_cmd_encode: maps kind/slot/data/phase to a 40-bit command word
module be_cmd_encode
    import be_cmd_pkg::*;
(
    input  logic [1:0]           kind,
    input  logic [2:0]           slot,
    input  logic [63:0]          data,
    input  logic                 phase,
    output logic [CMD_WIDTH-1:0] word
);

    // Phase 0 is the parameter high word, phase 1 the low word; other kinds ignore phase.
    always_comb begin
        word = data[39:0];
        case (kind)
            KIND_PARAM64: begin
                if (phase)
                    word = {OP_PARAM_LO, data[31:0]};
                else
                    word = {OP_PARAM_HI_BASE + {5'd0, slot}, data[63:32]};
            end
            KIND_END: word = {OP_END, 32'd0};
            default:  word = data[39:0];
        endcase
    end

endmodule

// File: rtl/be_cmd_writer.sv
// rtl/be_cmd_writer.sv - command FIFO producer; optional counters under BE_CMD_WRITER_STATS_EN
module be_cmd_writer
    import be_cmd_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 40
) (
    input  logic           clk,
    input  logic           rst_n,
    be_cmd_writer_if.slave bus,
    input  logic           abort,
    output logic           busy
`ifdef BE_CMD_WRITER_STATS_EN
    ,
    output logic [31:0]    words_written,
    output logic [31:0]    stall_cycles
`endif
);

    if (DATA_WIDTH != CMD_WIDTH) begin : g_width_check
        $error("be_cmd_writer: DATA_WIDTH must be 40");
    end

    localparam int CW = ADDRESS_WIDTH + 2;
    localparam logic [CW-1:0] DEPTH_W = CW'(2 ** ADDRESS_WIDTH);

    wr_state_t state;
    wr_state_t state_next;

    logic [1:0]           lat_kind;
    logic [2:0]           lat_slot;
    logic [63:0]          lat_data;
    logic [CW-1:0]        free;
    logic [CW-1:0]        need;
    logic                 space_ok;
    logic                 accept;
    logic                 write_next;
    logic                 phase_next;
    logic [CMD_WIDTH-1:0] word_next;

    assign bus.req_ready = (state == ST_IDLE) && !abort;
    assign accept        = bus.req_valid && bus.req_ready;

    // Occupancy lags a write by one cycle, so the word in flight is counted as used.
    assign free     = DEPTH_W - {1'b0, bus.fifo_data_count} - {{(CW-1){1'b0}}, bus.fifo_write};
    assign need     = {{(CW-2){1'b0}}, words_needed(lat_kind)};
    assign space_ok = (free >= need);

    // Next state; an abort in EMIT1 is ignored so a parameter pair is never split.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort)
                    state_next = ST_IDLE;
                else if (space_ok)
                    state_next = ST_EMIT1;
            end
            ST_EMIT1: state_next = (lat_kind == KIND_PARAM64) ? ST_EMIT2 : ST_IDLE;
            ST_EMIT2: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign write_next = (state_next == ST_EMIT1) || (state_next == ST_EMIT2);
    assign phase_next = (state_next == ST_EMIT2);

    be_cmd_encode u_encode (
        .kind  (lat_kind),
        .slot  (lat_slot),
        .data  (lat_data),
        .phase (phase_next),
        .word  (word_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Hold the accepted request until it is emitted; drop it on abort while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_kind <= 2'd0;
            lat_slot <= 3'd0;
            lat_data <= 64'd0;
        end else if (accept) begin
            lat_kind <= bus.req_kind;
            lat_slot <= bus.req_slot;
            lat_data <= bus.req_data;
        end else if ((state == ST_WAIT) && abort) begin
            lat_kind <= 2'd0;
            lat_slot <= 3'd0;
            lat_data <= 64'd0;
        end
    end

    // Registered FIFO strobe and data, high exactly while in EMIT1/EMIT2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.fifo_write      <= 1'b0;
            bus.fifo_write_data <= '0;
        end else begin
            bus.fifo_write <= write_next;
            if (write_next)
                bus.fifo_write_data <= word_next;
        end
    end

    assign busy = (state != ST_IDLE) || bus.fifo_write;

`ifdef BE_CMD_WRITER_STATS_EN
    // Free-running counters of emitted words and of cycles blocked on FIFO space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_written <= 32'd0;
            stall_cycles  <= 32'd0;
        end else begin
            if (bus.fifo_write)
                words_written <= words_written + 32'd1;
            if ((state == ST_WAIT) && !space_ok)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_be_cmd_writer.sv
// tb/tb_be_cmd_writer.sv - randomized self-checking bench for be_cmd_writer (BE_CMD_WRITER_STATS_EN aware)
`timescale 1ns/1ps
module tb_be_cmd_writer;

    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic busy;
`ifdef BE_CMD_WRITER_STATS_EN
    logic [31:0] words_written;
    logic [31:0] stall_cycles;
`endif

    be_cmd_writer_if #(.ADDRESS_WIDTH(AW)) bus ();

    be_cmd_writer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(40)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .abort         (abort),
        .busy          (busy)
`ifdef BE_CMD_WRITER_STATS_EN
        ,
        .words_written (words_written),
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [AW:0] occ = '0;
    logic [AW:0] fill_val = '0;
    bit          drain = 1'b1;
    bit          fill_set = 1'b0;
    bit          overflow_seen = 1'b0;
    logic [39:0] got_q[$];
    int          got_cyc[$];
    logic [39:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          reset_base = 0;

    assign bus.fifo_data_count = occ;

    // Cycle stamp.
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO occupancy model: registered count, optional one-per-cycle reader.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else if (fill_set) begin
            occ <= fill_val;
        end else begin
            if (({1'b0, occ} + {5'd0, bus.fifo_write}) > 6'd16)
                overflow_seen <= 1'b1;
            occ <= occ + {4'd0, bus.fifo_write} - {4'd0, (drain && occ != 0)};
        end
    end

    // Capture every written word with its cycle stamp.
    always @(negedge clk) begin
        if (rst_n && bus.fifo_write) begin
            got_q.push_back(bus.fifo_write_data);
            got_cyc.push_back(cyc);
        end
    end

    // Reference encoding computed straight from the command word definitions.
    task automatic model_push(input logic [1:0] k, input logic [2:0] s, input logic [63:0] d);
        logic [7:0] hi_op;
        hi_op = 8'h88 + 8'(s);
        if (k == 2'd1) begin
            exp_q.push_back({hi_op, d[63:32]});
            exp_q.push_back({8'h87, d[31:0]});
        end else if (k == 2'd2) begin
            exp_q.push_back(40'hBF00000000);
        end else begin
            exp_q.push_back(d[39:0]);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = 1'b0;
        bus.req_kind  = 2'd0;
        bus.req_slot  = 3'd0;
        bus.req_data  = 64'd0;
        abort = 1'b0;
        drain = 1'b1;
        fill_set = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        reset_base = got_q.size();
        exp_q.delete();
    endtask

    task automatic set_fill(input logic [AW:0] v);
        @(negedge clk);
        fill_val = v;
        fill_set = 1'b1;
        @(negedge clk);
        fill_set = 1'b0;
    endtask

    task automatic send(input logic [1:0] k, input logic [2:0] s, input logic [63:0] d, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_kind  = k;
        bus.req_slot  = s;
        bus.req_data  = d;
        for (int i = 0; i < 500 && !done; i++) begin
            if (bus.req_ready) begin
                acc = cyc;
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_accept got=timeout exp=accepted");
        end
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (got_q.size() < n && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        checks++;
        if (got_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout got=%0d words exp=%0d", name, got_q.size(), n);
        end
    endtask

    task automatic check_stream(input int base, input string name);
        int n;
        n = got_q.size() - base;
        checks++;
        if (n != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_word%0d got=%h exp=%h", name, i, got_q[base + i], exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic check_stats();
`ifdef BE_CMD_WRITER_STATS_EN
        checks++;
        if (words_written !== 32'(got_q.size() - reset_base)) begin
            errors++;
            $display("FAIL stats_words got=%0d exp=%0d", words_written, got_q.size() - reset_base);
        end
`endif
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (bus.fifo_write !== 1'b0) begin errors++; $display("FAIL reset_fifo_write got=%b exp=0", bus.fifo_write); end
        if (bus.fifo_write_data !== 40'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.fifo_write_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
`ifdef BE_CMD_WRITER_STATS_EN
        checks += 2;
        if (words_written !== 32'd0) begin errors++; $display("FAIL reset_words got=%0d exp=0", words_written); end
        if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stalls got=%0d exp=0", stall_cycles); end
`endif
    endtask

    task automatic test_raw_latency();
        int base, acc;
        base = got_q.size();
        send(2'd0, 3'd0, 64'h0000_0083_0000_0001, acc);
        model_push(2'd0, 3'd0, 64'h0000_0083_0000_0001);
        wait_words(base + 1, 20, "raw");
        checks++;
        if (got_q.size() > base && got_cyc[base] != acc + 2) begin
            errors++;
            $display("FAIL raw_latency got=%0d exp=%0d", got_cyc[base] - acc, 2);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL raw_busy_fall got=%b exp=0", busy); end
        check_stream(base, "raw");
    endtask

    task automatic test_param_fixed();
        logic [2:0]  slots[2];
        logic [63:0] datas[2];
        int base, acc;
        slots[0] = 3'd1; datas[0] = 64'h18171615_14131211;
        slots[1] = 3'd7; datas[1] = 64'h88878685_84838281;
        for (int v = 0; v < 2; v++) begin
            base = got_q.size();
            send(2'd1, slots[v], datas[v], acc);
            model_push(2'd1, slots[v], datas[v]);
            wait_words(base + 2, 20, "param");
            checks += 2;
            if (got_q.size() >= base + 2 && got_cyc[base] != acc + 2) begin
                errors++;
                $display("FAIL param_latency got=%0d exp=2", got_cyc[base] - acc);
            end
            if (got_q.size() >= base + 2 && got_cyc[base + 1] != got_cyc[base] + 1) begin
                errors++;
                $display("FAIL param_consecutive got=%0d exp=1", got_cyc[base + 1] - got_cyc[base]);
            end
            check_stream(base, "param");
        end
    endtask

    task automatic test_random();
        int base, acc;
        logic [1:0]  k;
        logic [2:0]  s;
        logic [63:0] d;
        base = got_q.size();
        for (int r = 0; r < 40; r++) begin
            k = 2'($urandom_range(3, 0));
            s = 3'($urandom_range(7, 0));
            d = {$urandom(), $urandom()};
            send(k, s, d, acc);
            model_push(k, s, d);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        wait_words(base + exp_q.size(), 300, "random");
        repeat (3) @(negedge clk);
        #1;
        check_stream(base, "random");
        check_stats();
    endtask

    task automatic test_full_boundary();
        int base, acc;
        logic [63:0] d;
`ifdef BE_CMD_WRITER_STATS_EN
        logic [31:0] stall0;
        stall0 = stall_cycles;
`endif
        drain = 1'b0;
        set_fill(5'd15);
        base = got_q.size();
        d = {$urandom(), $urandom()};
        send(2'd1, 3'd3, d, acc);
        model_push(2'd1, 3'd3, d);
        repeat (20) @(negedge clk);
        #1;
        checks += 2;
        if (got_q.size() != base) begin errors++; $display("FAIL full_split got=%0d words exp=0", got_q.size() - base); end
        if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got=%b exp=1", busy); end
`ifdef BE_CMD_WRITER_STATS_EN
        checks++;
        if ((stall_cycles - stall0) < 32'd20) begin
            errors++;
            $display("FAIL full_stalls got=%0d exp>=20", stall_cycles - stall0);
        end
`endif
        set_fill(5'd14);
        wait_words(base + 2, 20, "full");
        repeat (2) @(negedge clk);
        #1;
        checks += 3;
        if (got_q.size() >= base + 2 && got_cyc[base + 1] != got_cyc[base] + 1) begin
            errors++;
            $display("FAIL full_consecutive got=%0d exp=1", got_cyc[base + 1] - got_cyc[base]);
        end
        if (occ !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", occ); end
        if (overflow_seen) begin errors++; $display("FAIL full_overflow got=1 exp=0"); end
        check_stream(base, "full");
    endtask

    task automatic test_abort();
        int base, acc;
        logic [63:0] d;
        bit seen;
        base = got_q.size();
        send(2'd2, 3'd0, 64'd0, acc);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_wait_idle got=%b exp=0", busy); end
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_low got=%b exp=0", bus.req_ready); end
        abort = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_back got=%b exp=1", bus.req_ready); end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (got_q.size() != base) begin errors++; $display("FAIL abort_no_write got=%0d words exp=0", got_q.size() - base); end

        drain = 1'b1;
        set_fill(5'd0);
        base = got_q.size();
        d = {$urandom(), $urandom()};
        send(2'd1, 3'd5, d, acc);
        model_push(2'd1, 3'd5, d);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.fifo_write) seen = 1'b1;
        end
        abort = 1'b1;
        @(negedge clk);
        #1;
        checks += 2;
        if (bus.fifo_write !== 1'b1) begin errors++; $display("FAIL abort_emit_pair got=%b exp=1", bus.fifo_write); end
        if (bus.fifo_write_data !== {8'h87, d[31:0]}) begin
            errors++;
            $display("FAIL abort_emit_lo got=%h exp=%h", bus.fifo_write_data, {8'h87, d[31:0]});
        end
        abort = 1'b0;
        wait_words(base + 2, 20, "abort_pair");
        check_stream(base, "abort_pair");
    endtask

    task automatic test_back_to_back();
        int base, nacc;
        base = got_q.size();
        nacc = 0;
        @(negedge clk);
        bus.req_kind  = 2'd2;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 100 && nacc < 5; i++) begin
            #1;
            checks++;
            if (bus.req_ready !== !busy) begin
                errors++;
                $display("FAIL b2b_ready got=%b exp=%b", bus.req_ready, !busy);
            end
            if (bus.req_ready) nacc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) model_push(2'd2, 3'd0, 64'd0);
        wait_words(base + 5, 30, "b2b");
        for (int i = 0; i + 1 < 5 && base + i + 1 < got_q.size(); i++) begin
            checks++;
            if (got_cyc[base + i + 1] - got_cyc[base + i] != 3) begin
                errors++;
                $display("FAIL b2b_rate got=%0d exp=3", got_cyc[base + i + 1] - got_cyc[base + i]);
            end
        end
        check_stream(base, "b2b");
        check_stats();
    endtask

    task automatic test_reset_mid_pair();
        int acc;
        bit seen;
        send(2'd1, 3'd2, {$urandom(), $urandom()}, acc);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.fifo_write) seen = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus.fifo_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write got=%b exp=0", bus.fifo_write); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
`ifdef BE_CMD_WRITER_STATS_EN
        checks++;
        if (words_written !== 32'd0) begin errors++; $display("FAIL rst_mid_words got=%0d exp=0", words_written); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        reset_base = got_q.size();
        repeat (5) @(negedge clk);
        #1;
        checks += 2;
        if (got_q.size() != reset_base) begin errors++; $display("FAIL rst_mid_lo_leak got=%0d exp=0", got_q.size() - reset_base); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", bus.req_ready); end
    endtask

    initial begin
        test_reset();
        test_raw_latency();
        test_param_fixed();
        test_random();
        test_full_boundary();
        test_abort();
        test_back_to_back();
        test_reset_mid_pair();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
